// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl
//
// Sequential initiator for a single-cycle combinational ALU.
//
// A command (A, B, func, use_acc) is taken over a valid/ready handshake and
// registered onto the ALU operand/function inputs. After WAIT_CYCLES clock
// edges the ALU result, overflow and zero flags are captured into a response
// register. That register is offered over its own valid/ready handshake.
// The last captured result is kept in an accumulator. A later command can
// use the accumulator in place of operand A, so operations can be chained.
//
// Parameters:
//   WAIT_CYCLES      edges from driving ALU inputs to capturing outputs (1..15)
//
// Ports:
//   in_clk           clock, rising edge
//   in_rst           asynchronous active-high reset
//   in_cmd_valid     command presented
//   out_cmd_ready    block can accept a command (IDLE and not in reset)
//   in_cmd_A/B       operands (32 bit)
//   in_cmd_func      ALU function code (5 bit), passed through undecoded
//   in_cmd_use_acc   substitute accumulator for operand A
//   out_alu_A/B      registered operands to the ALU
//   out_alu_func     registered function code to the ALU
//   in_alu_result    ALU result
//   in_alu_overflow  ALU overflow flag
//   in_alu_zero      ALU zero flag
//   out_rsp_valid    response held
//   in_rsp_ready     consumer takes the response
//   out_rsp_result   captured result
//   out_rsp_overflow captured overflow flag
//   out_rsp_zero     captured zero flag
//
// Optional feature, macro ALU_SEQ_STICKY_OVF_EN:
//   out_ovf_sticky   set on any capture with overflow, cleared by in_ovf_clr
//                    (set wins over a clear on the same edge)
//   in_ovf_clr       clear request for out_ovf_sticky
module alu_seq_ctrl #(
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic        in_clk,
  input  logic        in_rst,
  input  logic        in_cmd_valid,
  output logic        out_cmd_ready,
  input  logic [31:0] in_cmd_A,
  input  logic [31:0] in_cmd_B,
  input  logic [4:0]  in_cmd_func,
  input  logic        in_cmd_use_acc,
  output logic [31:0] out_alu_A,
  output logic [31:0] out_alu_B,
  output logic [4:0]  out_alu_func,
  input  logic [31:0] in_alu_result,
  input  logic        in_alu_overflow,
  input  logic        in_alu_zero,
  output logic        out_rsp_valid,
  input  logic        in_rsp_ready,
  output logic [31:0] out_rsp_result,
  output logic        out_rsp_overflow,
  output logic        out_rsp_zero
`ifdef ALU_SEQ_STICKY_OVF_EN
  ,
  output logic        out_ovf_sticky,
  input  logic        in_ovf_clr
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  // The counter holds WAIT_CYCLES-1 at most, which fits in 4 bits for the
  // legal range 1..15.
  localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

  state_t      state_q;
  logic [3:0]  cnt_q;
  logic [31:0] acc_q;
  logic [31:0] alu_a_q;
  logic [31:0] alu_b_q;
  logic [4:0]  alu_func_q;
  logic        rsp_valid_q;
  logic [31:0] rsp_result_q;
  logic        rsp_ovf_q;
  logic        rsp_zero_q;

  logic        accept;
  logic        capture;

  // Ready is combinational so that it drops as soon as reset is asserted
  // and rises as soon as reset is released. No extra edge is needed.
  assign out_cmd_ready = (state_q == S_IDLE) && !in_rst;
  assign accept        = in_cmd_valid && out_cmd_ready;
  assign capture       = (state_q == S_EXEC) && (cnt_q == '0);

  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      acc_q        <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_func_q   <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= '0;
      rsp_ovf_q    <= 1'b0;
      rsp_zero_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            alu_a_q    <= in_cmd_use_acc ? acc_q : in_cmd_A;
            alu_b_q    <= in_cmd_B;
            alu_func_q <= in_cmd_func;
            cnt_q      <= CNT_LOAD;
            state_q    <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (capture) begin
            rsp_result_q <= in_alu_result;
            rsp_ovf_q    <= in_alu_overflow;
            rsp_zero_q   <= in_alu_zero;
            acc_q        <= in_alu_result;
            rsp_valid_q  <= 1'b1;
            state_q      <= S_RESP;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        S_RESP: begin
          // Returning to IDLE here means no new command can be accepted on
          // the same edge that the response is consumed.
          if (in_rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign out_alu_A        = alu_a_q;
  assign out_alu_B        = alu_b_q;
  assign out_alu_func     = alu_func_q;
  assign out_rsp_valid    = rsp_valid_q;
  assign out_rsp_result   = rsp_result_q;
  assign out_rsp_overflow = rsp_ovf_q;
  assign out_rsp_zero     = rsp_zero_q;

`ifdef ALU_SEQ_STICKY_OVF_EN
  logic ovf_sticky_q;

  // Set has priority, so a clear cannot hide an overflow captured on the
  // same edge.
  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      ovf_sticky_q <= 1'b0;
    end else if (capture && in_alu_overflow) begin
      ovf_sticky_q <= 1'b1;
    end else if (in_ovf_clr) begin
      ovf_sticky_q <= 1'b0;
    end
  end

  assign out_ovf_sticky = ovf_sticky_q;
`endif

endmodule

// File: tb/tb_alu_seq_ctrl.sv
module tb_alu_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] cA, cB;
  logic [4:0]  cF;
  logic        cU;
  logic        v1, v3, v4;
  logic        r1, r3, r4;

  logic        rdy1, rdy3, rdy4;
  logic [31:0] aA1, aA3, aA4, aB1, aB3, aB4;
  logic [4:0]  aF1, aF3, aF4;
  logic [31:0] res1, res3, res4;
  logic        ovf1, ovf3, ovf4, zr1, zr3, zr4;
  logic        rv1, rv3, rv4;
  logic [31:0] rr1, rr3, rr4;
  logic        ro1, ro3, ro4, rz1, rz3, rz4;
`ifdef ALU_SEQ_STICKY_OVF_EN
  logic        st1, st3, st4;
  logic        clr1;
  logic        clr0 = 1'b0;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  // Stub ALU: ADD (with signed overflow), AND, OR, XOR.
  function automatic logic [33:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                         input logic [4:0] f);
    logic [31:0] r;
    logic        o;
    r = '0;
    o = 1'b0;
    case (f)
      5'b00000: begin
        r = a + b;
        o = (a[31] == b[31]) && (r[31] != a[31]);
      end
      5'b11000: r = a & b;
      5'b11001: r = a | b;
      5'b11011: r = a ^ b;
      default:  r = '0;
    endcase
    return {o, (r == 32'd0), r};
  endfunction

  assign {ovf1, zr1, res1} = alu_f(aA1, aB1, aF1);
  assign {ovf3, zr3, res3} = alu_f(aA3, aB3, aF3);
  assign {ovf4, zr4, res4} = alu_f(aA4, aB4, aF4);

  alu_seq_ctrl #(.WAIT_CYCLES(1)) u1 (
`ifdef ALU_SEQ_STICKY_OVF_EN
    .out_ovf_sticky(st1), .in_ovf_clr(clr1),
`endif
    .in_clk(clk), .in_rst(rst), .in_cmd_valid(v1), .out_cmd_ready(rdy1),
    .in_cmd_A(cA), .in_cmd_B(cB), .in_cmd_func(cF), .in_cmd_use_acc(cU),
    .out_alu_A(aA1), .out_alu_B(aB1), .out_alu_func(aF1),
    .in_alu_result(res1), .in_alu_overflow(ovf1), .in_alu_zero(zr1),
    .out_rsp_valid(rv1), .in_rsp_ready(r1), .out_rsp_result(rr1),
    .out_rsp_overflow(ro1), .out_rsp_zero(rz1)
  );

  alu_seq_ctrl #(.WAIT_CYCLES(3)) u3 (
`ifdef ALU_SEQ_STICKY_OVF_EN
    .out_ovf_sticky(st3), .in_ovf_clr(clr0),
`endif
    .in_clk(clk), .in_rst(rst), .in_cmd_valid(v3), .out_cmd_ready(rdy3),
    .in_cmd_A(cA), .in_cmd_B(cB), .in_cmd_func(cF), .in_cmd_use_acc(cU),
    .out_alu_A(aA3), .out_alu_B(aB3), .out_alu_func(aF3),
    .in_alu_result(res3), .in_alu_overflow(ovf3), .in_alu_zero(zr3),
    .out_rsp_valid(rv3), .in_rsp_ready(r3), .out_rsp_result(rr3),
    .out_rsp_overflow(ro3), .out_rsp_zero(rz3)
  );

  alu_seq_ctrl #(.WAIT_CYCLES(4)) u4 (
`ifdef ALU_SEQ_STICKY_OVF_EN
    .out_ovf_sticky(st4), .in_ovf_clr(clr0),
`endif
    .in_clk(clk), .in_rst(rst), .in_cmd_valid(v4), .out_cmd_ready(rdy4),
    .in_cmd_A(cA), .in_cmd_B(cB), .in_cmd_func(cF), .in_cmd_use_acc(cU),
    .out_alu_A(aA4), .out_alu_B(aB4), .out_alu_func(aF4),
    .in_alu_result(res4), .in_alu_overflow(ovf4), .in_alu_zero(zr4),
    .out_rsp_valid(rv4), .in_rsp_ready(r4), .out_rsp_result(rr4),
    .out_rsp_overflow(ro4), .out_rsp_zero(rz4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    cA = '0; cB = '0; cF = '0; cU = 1'b0;
    v1 = 1'b0; v3 = 1'b0; v4 = 1'b0;
    r1 = 1'b0; r3 = 1'b0; r4 = 1'b0;
`ifdef ALU_SEQ_STICKY_OVF_EN
    clr1 = 1'b0;
`endif

    // Reset state
    #3;
    chk("rst_ready", 32'(rdy1), 32'd0);
    chk("rst_rsp_valid", 32'(rv1), 32'd0);
    chk("rst_alu_A", aA1, 32'd0);
    chk("rst_rsp_result", rr1, 32'd0);
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("rel_ready1", 32'(rdy1), 32'd1);
    chk("rel_ready3", 32'(rdy3), 32'd1);
    chk("rel_ready4", 32'(rdy4), 32'd1);
`ifdef ALU_SEQ_STICKY_OVF_EN
    chk("rst_sticky", 32'(st1), 32'd0);
`endif

    // AND, WAIT_CYCLES=1
    cA = 32'hF0F0_0000; cB = 32'h0FF0_0000; cF = 5'b11000; v1 = 1'b1; r1 = 1'b1;
    tick();
    v1 = 1'b0;
    chk("and_valid_early", 32'(rv1), 32'd0);
    chk("and_alu_A", aA1, 32'hF0F0_0000);
    chk("and_alu_B", aB1, 32'h0FF0_0000);
    chk("and_alu_func", 32'(aF1), 32'(5'b11000));
    chk("and_busy", 32'(rdy1), 32'd0);
    tick();
    chk("and_valid", 32'(rv1), 32'd1);
    chk("and_result", rr1, 32'h00F0_0000);
    chk("and_zero", 32'(rz1), 32'd0);
    tick();
    chk("and_consumed", 32'(rv1), 32'd0);
    chk("and_idle_ready", 32'(rdy1), 32'd1);
    chk("and_result_held", rr1, 32'h00F0_0000);

    // XOR to zero
    cA = 32'h1234_5678; cB = 32'h1234_5678; cF = 5'b11011; v1 = 1'b1;
    tick();
    v1 = 1'b0;
    tick();
    chk("xor_valid", 32'(rv1), 32'd1);
    chk("xor_result", rr1, 32'd0);
    chk("xor_zero", 32'(rz1), 32'd1);
    tick();

    // Chaining through the accumulator
    cA = 32'h0000_00F0; cB = 32'h0000_000F; cF = 5'b11001; v1 = 1'b1;
    tick();
    v1 = 1'b0;
    tick();
    chk("or_result", rr1, 32'h0000_00FF);
    tick();
    cU = 1'b1; cA = 32'hDEAD_BEEF; cB = 32'hFFFF_FF00; cF = 5'b11000; v1 = 1'b1;
    tick();
    v1 = 1'b0; cU = 1'b0;
    chk("chain_alu_A", aA1, 32'h0000_00FF);
    tick();
    chk("chain_result", rr1, 32'd0);
    chk("chain_zero", 32'(rz1), 32'd1);
    tick();

    // Backpressure, WAIT_CYCLES=3
    r3 = 1'b0;
    cA = 32'h0000_0A00; cB = 32'h0000_0055; cF = 5'b11001; v3 = 1'b1;
    tick();
    v3 = 1'b0;
    chk("bp_valid_e1", 32'(rv3), 32'd0);
    tick();
    chk("bp_valid_e2", 32'(rv3), 32'd0);
    tick();
    chk("bp_valid_e3", 32'(rv3), 32'd0);
    tick();
    chk("bp_valid_at3", 32'(rv3), 32'd1);
    chk("bp_result", rr3, 32'h0000_0A55);
    // New command presented while busy must be ignored
    cA = 32'h1234_5678; cB = 32'd0; cF = 5'b11011; v3 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("bp_hold_valid%0d", i), 32'(rv3), 32'd1);
      chk($sformatf("bp_hold_result%0d", i), rr3, 32'h0000_0A55);
      chk($sformatf("bp_hold_zero%0d", i), 32'(rz3), 32'd0);
      chk($sformatf("bp_hold_ready%0d", i), 32'(rdy3), 32'd0);
      chk($sformatf("bp_hold_alu_A%0d", i), aA3, 32'h0000_0A00);
    end
    r3 = 1'b1;
    tick();
    chk("bp_consumed_valid", 32'(rv3), 32'd0);
    chk("bp_consumed_ready", 32'(rdy3), 32'd1);
    chk("bp_no_same_cycle_accept", aA3, 32'h0000_0A00);
    tick();
    v3 = 1'b0;
    chk("bp_next_accept_busy", 32'(rdy3), 32'd0);
    chk("bp_next_alu_A", aA3, 32'h1234_5678);
    tick();
    tick();
    chk("bp_next_early", 32'(rv3), 32'd0);
    tick();
    chk("bp_next_valid", 32'(rv3), 32'd1);
    chk("bp_next_result", rr3, 32'h1234_5678);
    tick();

    // Reset mid-EXEC, WAIT_CYCLES=4
    r4 = 1'b1;
    cA = 32'h0000_0011; cB = 32'h0000_0022; cF = 5'b11001; v4 = 1'b1;
    tick();
    v4 = 1'b0;
    repeat (4) tick();
    chk("w4_valid", 32'(rv4), 32'd1);
    chk("w4_result", rr4, 32'h0000_0033);
    tick();
    cA = 32'h0000_0005; cB = 32'h0000_0003; cF = 5'b11011; v4 = 1'b1;
    tick();
    v4 = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    chk("mid_rst_ready", 32'(rdy4), 32'd0);
    chk("mid_rst_alu_A", aA4, 32'd0);
    chk("mid_rst_alu_B", aB4, 32'd0);
    chk("mid_rst_alu_func", 32'(aF4), 32'd0);
    chk("mid_rst_valid", 32'(rv4), 32'd0);
    chk("mid_rst_result", rr4, 32'd0);
    #1;
    rst = 1'b0;
    #1;
    chk("mid_rel_ready", 32'(rdy4), 32'd1);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk($sformatf("mid_no_rsp%0d", i), 32'(rv4), 32'd0);
    end
    cU = 1'b1; cA = 32'hFFFF_FFFF; cB = 32'd0; cF = 5'b11001; v4 = 1'b1;
    tick();
    v4 = 1'b0; cU = 1'b0;
    chk("acc_cleared_alu_A", aA4, 32'd0);
    repeat (4) tick();
    chk("acc_cleared_valid", 32'(rv4), 32'd1);
    chk("acc_cleared_result", rr4, 32'd0);
    chk("acc_cleared_zero", 32'(rz4), 32'd1);
    tick();

`ifdef ALU_SEQ_STICKY_OVF_EN
    r1 = 1'b1;
    cA = 32'h7FFF_FFFF; cB = 32'd1; cF = 5'b00000; v1 = 1'b1;
    tick();
    v1 = 1'b0;
    tick();
    chk("st_ovf", 32'(ro1), 32'd1);
    chk("st_set", 32'(st1), 32'd1);
    tick();
    for (int i = 0; i < 2; i++) begin
      cA = 32'd1; cB = 32'd1; cF = 5'b00000; v1 = 1'b1;
      tick();
      v1 = 1'b0;
      tick();
      chk($sformatf("st_noovf%0d", i), 32'(ro1), 32'd0);
      chk($sformatf("st_hold%0d", i), 32'(st1), 32'd1);
      tick();
    end
    clr1 = 1'b1;
    tick();
    clr1 = 1'b0;
    chk("st_cleared", 32'(st1), 32'd0);
    cA = 32'h7FFF_FFFF; cB = 32'd1; cF = 5'b00000; v1 = 1'b1;
    tick();
    v1 = 1'b0;
    clr1 = 1'b1;
    tick();
    clr1 = 1'b0;
    chk("st_set_wins", 32'(st1), 32'd1);
    tick();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_seq_ctrl.md
# alu_seq_ctrl

Sequential initiator for the single-cycle combinational ALU: accepts ALU commands over a valid/ready handshake, registers and drives the ALU's operand and function inputs, waits a fixed settling time, then captures result, overflow and zero flags into a response register with its own valid/ready handshake. It sits between an instruction or test sequencer and the ALU. It also keeps an accumulator of the last result so that operations can be chained.

## Interface
Parameters:
- WAIT_CYCLES, 1: clock edges from driving the ALU inputs to capturing its outputs; legal range 1..15.

Ports:
- in_clk  input  1  clock; all state updates on the rising edge.
- in_rst  input  1  reset, asynchronous, active-high.
- in_cmd_valid  input  1  a command is presented.
- out_cmd_ready  output  1  the block can accept a command.
- in_cmd_A  input  32  operand A.
- in_cmd_B  input  32  operand B.
- in_cmd_func  input  5  ALU function code, passed through undecoded.
- in_cmd_use_acc  input  1  when set, the accumulator replaces in_cmd_A.
- out_alu_A  output  32  registered operand A to the ALU.
- out_alu_B  output  32  registered operand B to the ALU.
- out_alu_func  output  5  registered function code to the ALU.
- in_alu_result  input  32  ALU result.
- in_alu_overflow  input  1  ALU overflow flag.
- in_alu_zero  input  1  ALU zero flag.
- out_rsp_valid  output  1  a response is held.
- in_rsp_ready  input  1  the consumer takes the response.
- out_rsp_result  output  32  captured result.
- out_rsp_overflow  output  1  captured overflow.
- out_rsp_zero  output  1  captured zero.

## Operation
- States:
  - IDLE: out_cmd_ready = 1 (forced to 0 while in_rst is high).
  - EXEC: out_cmd_ready = 0; wait counter runs.
  - RESP: out_rsp_valid = 1.
- IDLE → EXEC when in_cmd_valid and out_cmd_ready are both high at an edge. On that edge:
  - out_alu_A ← (in_cmd_use_acc ? acc : in_cmd_A);
  - out_alu_B ← in_cmd_B;
  - out_alu_func ← in_cmd_func;
  - wait counter ← WAIT_CYCLES − 1.
- EXEC: the counter decrements each edge. The edge on which the counter reads 0 captures in_alu_result, in_alu_overflow and in_alu_zero into the out_rsp_* registers, loads acc with in_alu_result, and moves to RESP.
- RESP → IDLE on the edge where in_rsp_ready is high. The out_rsp_* registers and out_alu_* stay unchanged until the next accept.
- out_alu_* change only on an accept edge; the ALU inputs are stable for the whole EXEC and RESP period.
- No decode of in_cmd_func and no result arithmetic; widths pass through unchanged.
- in_cmd_* are ignored outside IDLE.
- A new command cannot be accepted in the same cycle that a response is consumed.

## Timing
- Reset (asynchronous, immediate), all to 0: state IDLE, out_alu_A/B, out_alu_func, acc, out_rsp_result, out_rsp_overflow, out_rsp_zero, out_rsp_valid, counter. out_cmd_ready becomes 1 after in_rst deasserts.
- Accept at edge k → capture at edge k+WAIT_CYCLES → out_rsp_valid high from just after edge k+WAIT_CYCLES.
- Response consumed at edge r → out_cmd_ready high after r. Minimum command period is WAIT_CYCLES+2 cycles.
- Backpressure: with in_rsp_ready held low, RESP holds indefinitely and all outputs are stable.
- Reset mid-EXEC or mid-RESP: the pending operation is discarded and no response is issued; acc returns to 0.
- in_cmd_use_acc on the first command after reset uses acc = 0.

## Configuration
- ALU_SEQ_STICKY_OVF_EN defined:
  - adds output out_ovf_sticky (1 bit) and input in_ovf_clr (1 bit);
  - out_ovf_sticky is set on any capture edge with in_alu_overflow = 1;
  - it is cleared on an edge with in_ovf_clr = 1; set wins if both happen on the same edge;
  - it resets to 0.
- Not defined: neither port exists and no sticky state is built.

## Test plan
- AND: A=0xF0F0_0000, B=0x0FF0_0000, func=11000, WAIT_CYCLES=1, rsp_ready=1 → out_rsp_valid one edge after accept; result 0x00F0_0000, zero=0.
- XOR to zero: A=B=0x1234_5678, func=11011 → result 0x0000_0000, zero=1.
- Chaining: OR with A=0x0000_00F0, B=0x0000_000F → 0x0000_00FF. Then use_acc=1, B=0xFFFF_FF00, func=11000 → 0x0000_0000, zero=1; out_alu_A observed as 0x0000_00FF.
- Backpressure, WAIT_CYCLES=3: hold in_rsp_ready low for 5 cycles after valid → result and flags stable, out_cmd_ready=0 throughout. Assert ready → IDLE, next command accepted one cycle later. Accept-to-valid is exactly 3 edges.
- Reset mid-EXEC (WAIT_CYCLES=4, in_rst pulsed on the second EXEC cycle) → all outputs 0 immediately, no out_rsp_valid, out_cmd_ready=1 after release.
- ALU_SEQ_STICKY_OVF_EN with a stub ALU driving overflow=1 on one op, then 0 on two ops → out_ovf_sticky stays 1. Pulse in_ovf_clr → 0. Overflow capture and in_ovf_clr on the same edge → 1.
